// File: rtl/digit_scan_pkg.sv
// Shared types and sizing for the multiplexed digit scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package digit_scan_pkg;

  localparam int DWELL_W = 8;
  localparam int BLANK_W = 4;
  localparam int NDIG    = 4;
  localparam int SEL_W   = $clog2(NDIG);
  // One down-counter serves both phases, so it is sized for the longer one.
  localparam int CNT_W   = (DWELL_W > BLANK_W) ? DWELL_W : BLANK_W;

  // Starting a next-digit search from the top index yields the lowest set bit.
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

endpackage

// File: rtl/scan_next_sel.sv
// Finds the first enabled digit strictly after cur, searching upward modulo NDIG.
// Latency: combinational.
// Backpressure: none; pure function of mask and cur.
module scan_next_sel
  import digit_scan_pkg::*;
(
  input  logic [NDIG-1:0]  mask,
  input  logic [SEL_W-1:0] cur,
  output logic [SEL_W-1:0] nxt,
  output logic             wrap
);

  logic             found;
  logic [SEL_W-1:0] idx;

  // Rotating priority search; offset NDIG lands back on cur, covering a single-digit mask.
  always_comb begin
    nxt   = cur;
    found = 1'b0;
    idx   = cur;
    for (int k = 1; k <= NDIG; k++) begin
      idx = cur + SEL_W'(k);
      if (!found && mask[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
    wrap = (nxt <= cur);
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed digit scanner: per enabled digit, BLANK (e=1) then SHOW (e=0) for dwell+1 cycles.
// Latency: outputs registered; a start request in IDLE selects the first digit on the next cycle.
// Backpressure: none; run is a level request and a digit always completes before the scan idles.
module digit_scan_ctrl
  import digit_scan_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [NDIG-1:0]    mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [BLANK_W-1:0] blank,
  output logic [SEL_W-1:0]   w,
  output logic               e,
  output logic               digit_done,
  output logic               frame_done,
  output logic               busy
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [SEL_W-1:0] w_nxt;
  logic             e_nxt, dd_nxt, fd_nxt, busy_nxt;

  logic             go;
  logic             cnt_zero;
  logic             has_blank;
  logic [SEL_W-1:0] sel_cur, sel_nxt;
  logic             sel_wrap;
  logic [CNT_W-1:0] digit_load;

  assign go        = run && (mask != '0);
  assign cnt_zero  = (cnt == '0);
  assign has_blank = (blank != '0);
  // Entering a digit loads the blank length, or the dwell directly when blanking is off.
  assign digit_load = has_blank ? (CNT_W'(blank) - CNT_W'(1)) : CNT_W'(dwell);
  // From IDLE the search starts above the top index so it returns the lowest set bit.
  assign sel_cur   = (state == IDLE) ? LAST_IDX : w;

  scan_next_sel u_next_sel (
    .mask (mask),
    .cur  (sel_cur),
    .nxt  (sel_nxt),
    .wrap (sel_wrap)
  );

  // State, counter and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      w          <= '0;
      e          <= 1'b1;
      digit_done <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      w          <= w_nxt;
      e          <= e_nxt;
      digit_done <= dd_nxt;
      frame_done <= fd_nxt;
      busy       <= busy_nxt;
    end
  end

  // Next-state: phases advance only when the down-counter reaches zero.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = has_blank ? BLANK : SHOW;
      BLANK:   if (cnt_zero) state_nxt = SHOW;
      SHOW: begin
        if (cnt_zero) begin
          if (go) state_nxt = has_blank ? BLANK : SHOW;
          else    state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output/datapath next values; w only moves at digit entry, never inside a SHOW.
  always_comb begin
    cnt_nxt  = cnt_zero ? cnt : (cnt - CNT_W'(1));
    w_nxt    = w;
    dd_nxt   = 1'b0;
    fd_nxt   = 1'b0;
    e_nxt    = (state_nxt != SHOW);
    busy_nxt = (state_nxt != IDLE);
    case (state)
      IDLE: begin
        if (go) begin
          w_nxt   = sel_nxt;
          cnt_nxt = digit_load;
        end
      end
      BLANK: begin
        if (cnt_zero) cnt_nxt = CNT_W'(dwell);
      end
      SHOW: begin
        if (cnt_zero) begin
          dd_nxt = 1'b1;
          if (go) begin
            w_nxt   = sel_nxt;
            fd_nxt  = sel_wrap;
            cnt_nxt = digit_load;
          end
        end
      end
      default: begin
        cnt_nxt = '0;
      end
    endcase
  end

endmodule
